nebula_mem_arbiter: RTL
=======================

NEBULA_MEM_ARBITER -- requirements
Module: nebula_mem_arbiter

Interface
REQ-001 SHALL have parameter PADDR_WIDTH, default 56, physical address width.
REQ-002 SHALL have parameter LINE_BYTES, default 64, cache line size in bytes; the line data width is LINE_BYTES*8.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024, bus watchdog limit; 0 disables the watchdog.
REQ-004 SHALL have port clk, input, 1, clock.
REQ-005 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have port icache_req, input, 1, I-cache refill read request, held high until icache_ack.
REQ-007 SHALL have port icache_addr, input, PADDR_WIDTH, line address for the I-cache refill.
REQ-008 SHALL have port icache_ack, output, 1, one-cycle completion pulse to the I-cache.
REQ-009 SHALL have port dcache_req, input, 1, D-cache refill or writeback request, held high until dcache_ack.
REQ-010 SHALL have port dcache_we, input, 1, 1 = line write, 0 = line read.
REQ-011 SHALL have port dcache_addr, input, PADDR_WIDTH, line address for the D-cache request.
REQ-012 SHALL have port dcache_wdata, input, LINE_BYTES*8, writeback line data.
REQ-013 SHALL have port dcache_ack, output, 1, one-cycle completion pulse to the D-cache.
REQ-014 SHALL have port ptw_req, input, 1, page-table walker PTE read request, held high until ptw_ack.
REQ-015 SHALL have port ptw_addr, input, PADDR_WIDTH, 8-byte-aligned PTE address.
REQ-016 SHALL have port ptw_ack, output, 1, one-cycle completion pulse to the PTW.
REQ-017 SHALL have port ptw_rdata, output, 64, selected PTE doubleword.
REQ-018 SHALL have port resp_line, output, LINE_BYTES*8, registered read line, valid during any ack.
REQ-019 SHALL have port resp_error, output, 1, asserted with an ack when the transaction failed.
REQ-020 SHALL have port bus_req, output, 1, downstream request, held high until bus_ack or bus_error.
REQ-021 SHALL have port bus_we, output, 1, downstream write enable.
REQ-022 SHALL have port bus_addr, output, PADDR_WIDTH, downstream address, always line-aligned.
REQ-023 SHALL have port bus_wdata, output, LINE_BYTES*8, downstream write line.
REQ-024 SHALL have port bus_ack, input, 1, downstream completion.
REQ-025 SHALL have port bus_rdata, input, LINE_BYTES*8, downstream read line.
REQ-026 SHALL have port bus_error, input, 1, downstream error, which also terminates the transaction.

Function
REQ-027 SHALL implement an FSM with states IDLE, BUSY and RESP. IDLE goes to BUSY when any request is pending. BUSY goes to RESP on bus_ack, bus_error or watchdog expiry. RESP goes to IDLE unconditionally.
REQ-028 SHALL pick the winner in IDLE by round-robin over the order PTW, DCACHE, ICACHE. The requester just served gets lowest priority next time, and the pointer advances only on a grant.
REQ-029 SHALL latch the source, we, line-aligned address (low log2(LINE_BYTES) bits cleared), wdata and PTE offset addr[5:3] on the IDLE-to-BUSY edge. bus_* outputs are driven only from these latches and stay stable throughout BUSY.
REQ-030 SHALL assert bus_req exactly while in BUSY. A request seen in IDLE cycle N gives bus_req high in cycle N+1.
REQ-031 SHALL, when the transaction terminates in cycle M, register bus_rdata into resp_line and drive the winner's ack in cycle M+1 (RESP).
REQ-032 SHALL set resp_error in cycle M+1 to bus_error, or to 1 on timeout; resp_error is 0 otherwise.
REQ-033 SHALL drive ptw_rdata as doubleword offset [5:3] of the registered line.
REQ-034 SHALL count BUSY cycles when TIMEOUT_CYCLES != 0. The count reaching TIMEOUT_CYCLES with no bus_ack or bus_error forces termination with an error. The counter clears on entering BUSY.
REQ-035 SHALL ignore request changes during BUSY and RESP. Requesters deassert req on the cycle after their ack; the earliest re-arbitration is cycle M+2.
REQ-036 SHALL resolve simultaneous bus_ack and bus_error as an error termination.
REQ-037 SHALL hold all acks low outside RESP, with at most one ack high per cycle.

Reset
REQ-038 SHALL, with rst_n low, go to IDLE at once and drive bus_req, bus_we, all acks and resp_error to 0. Latches, resp_line and the counter clear to 0, and the round-robin pointer resets to PTW. Any in-flight bus transaction is abandoned.

Structure
REQ-039 SHALL put the arb_state_t enum (IDLE/BUSY/RESP) and the arb_src_t enum (SRC_PTW/SRC_DCACHE/SRC_ICACHE) in nebula_pkg.
REQ-040 SHALL use one sub-module, nebula_rr_arbiter: a 3-way round-robin picker with inputs req[2:0] and a pointer, and a one-hot grant output.

Verification
REQ-041 Bench SHALL drive icache_req with addr 0x80001234 and bus_ack 3 cycles later; bus_addr shall be 0x80001200, and icache_ack shall pulse one cycle after bus_ack with resp_error=0.
REQ-042 Bench SHALL raise all three requests together; grants shall go PTW, DCACHE, ICACHE, and a held PTW re-request shall follow ICACHE.
REQ-043 Bench SHALL drive ptw_addr 0x1028 with bus_rdata doubleword 5 = 0xDEADBEEF; ptw_rdata shall be 0xDEADBEEF with ptw_ack=1.
REQ-044 Bench SHALL run a dcache write with wdata pattern A5 repeated; bus_we=1 and bus_wdata shall equal the pattern throughout BUSY, and dcache_ack shall follow.
REQ-045 Bench SHALL set TIMEOUT_CYCLES=8 and never assert bus_ack; the ack with resp_error=1 shall arrive 8 cycles after bus_req rose, and bus_error alone shall also give resp_error=1.
REQ-046 Bench SHALL pull rst_n low mid-BUSY; bus_req shall fall at once, and after release a new request shall be granted to PTW first.

Source files
------------

// File: rtl/nebula_pkg.sv
// Shared types for the Nebula memory arbiter: FSM states, requester IDs and
// the fixed round-robin order PTW -> DCACHE -> ICACHE.
package nebula_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        SRC_PTW    = 2'd0,
        SRC_DCACHE = 2'd1,
        SRC_ICACHE = 2'd2
    } arb_src_t;

    localparam int unsigned NUM_SRC = 3;

    function automatic arb_src_t next_src(input arb_src_t s);
        case (s)
            SRC_PTW:    return SRC_DCACHE;
            SRC_DCACHE: return SRC_ICACHE;
            default:    return SRC_PTW;
        endcase
    endfunction

endpackage

// File: rtl/nebula_rr_arbiter.sv
// Three-way round-robin picker: the source named by ptr has top priority and
// the search wraps in PTW -> DCACHE -> ICACHE order; grant is one-hot or zero.
module nebula_rr_arbiter
    import nebula_pkg::*;
(
    input  logic [2:0] req,
    input  arb_src_t   ptr,
    output logic [2:0] grant
);

    arb_src_t cand;

    always_comb begin
        grant = '0;
        cand  = ptr;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (grant == '0 && req[cand]) begin
                grant[cand] = 1'b1;
            end
            cand = next_src(cand);
        end
    end

endmodule

// File: rtl/nebula_mem_arbiter.sv
// Single-outstanding line arbiter sharing one downstream bus between the
// PTW, D-cache and I-cache, with an optional BUSY watchdog.
module nebula_mem_arbiter
    import nebula_pkg::*;
#(
    parameter int PADDR_WIDTH    = 56,
    parameter int LINE_BYTES     = 64,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    icache_req,
    input  logic [PADDR_WIDTH-1:0]  icache_addr,
    output logic                    icache_ack,
    input  logic                    dcache_req,
    input  logic                    dcache_we,
    input  logic [PADDR_WIDTH-1:0]  dcache_addr,
    input  logic [LINE_BYTES*8-1:0] dcache_wdata,
    output logic                    dcache_ack,
    input  logic                    ptw_req,
    input  logic [PADDR_WIDTH-1:0]  ptw_addr,
    output logic                    ptw_ack,
    output logic [63:0]             ptw_rdata,
    output logic [LINE_BYTES*8-1:0] resp_line,
    output logic                    resp_error,
    output logic                    bus_req,
    output logic                    bus_we,
    output logic [PADDR_WIDTH-1:0]  bus_addr,
    output logic [LINE_BYTES*8-1:0] bus_wdata,
    input  logic                    bus_ack,
    input  logic [LINE_BYTES*8-1:0] bus_rdata,
    input  logic                    bus_error
);

    localparam int OFF_W = $clog2(LINE_BYTES);
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [PADDR_WIDTH-1:0] LINE_MASK = {PADDR_WIDTH{1'b1}} << OFF_W;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    arb_state_t             state;
    arb_src_t               src;
    arb_src_t               rr_ptr;
    arb_src_t               win_src;
    logic [2:0]             grant;
    logic [PADDR_WIDTH-1:0] sel_addr;
    logic [2:0]             pte_off;
    logic [CNT_W-1:0]       cnt;
    logic                   timeout;

    nebula_rr_arbiter u_rr (
        .req   ({icache_req, dcache_req, ptw_req}),
        .ptr   (rr_ptr),
        .grant (grant)
    );

    always_comb begin
        win_src  = SRC_PTW;
        sel_addr = ptw_addr;
        if (grant[1]) begin
            win_src  = SRC_DCACHE;
            sel_addr = dcache_addr;
        end else if (grant[2]) begin
            win_src  = SRC_ICACHE;
            sel_addr = icache_addr;
        end
    end

    // cnt holds the number of BUSY cycles already completed, so the limit is hit
    // in the TIMEOUT_CYCLES-th BUSY cycle.
    assign timeout = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);

    assign ptw_rdata = resp_line[{pte_off, 6'd0} +: 64];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            src        <= SRC_PTW;
            rr_ptr     <= SRC_PTW;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            pte_off    <= '0;
            cnt        <= '0;
            resp_line  <= '0;
            resp_error <= 1'b0;
            ptw_ack    <= 1'b0;
            dcache_ack <= 1'b0;
            icache_ack <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant != '0) begin
                        state     <= BUSY;
                        bus_req   <= 1'b1;
                        src       <= win_src;
                        rr_ptr    <= next_src(win_src);
                        bus_we    <= (win_src == SRC_DCACHE) && dcache_we;
                        bus_addr  <= sel_addr & LINE_MASK;
                        bus_wdata <= (win_src == SRC_DCACHE) ? dcache_wdata : '0;
                        pte_off   <= sel_addr[5:3];
                        cnt       <= '0;
                    end
                end
                BUSY: begin
                    if (bus_ack || bus_error || timeout) begin
                        state      <= RESP;
                        bus_req    <= 1'b0;
                        resp_line  <= bus_rdata;
                        // an ack landing on the limit cycle still counts as success
                        resp_error <= bus_error || (timeout && !bus_ack);
                        ptw_ack    <= (src == SRC_PTW);
                        dcache_ack <= (src == SRC_DCACHE);
                        icache_ack <= (src == SRC_ICACHE);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    state      <= IDLE;
                    resp_error <= 1'b0;
                    ptw_ack    <= 1'b0;
                    dcache_ack <= 1'b0;
                    icache_ack <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
